// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/block types and L2 arbiter grant encoding
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  // Which L1 currently owns the L2 port; also used by the performance counters
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ICACHE = 2'd1,
    DCACHE = 2'd2
  } l2arb_grant_t;

endpackage

// File: rtl/l2arb_rr_select.sv
// rtl/l2arb_rr_select.sv - combinational winner selection between I-cache and D-cache
module l2arb_rr_select
  import lc3b_types::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic         req_i,
  input  logic         req_d,
  input  l2arb_grant_t last_served,
  output l2arb_grant_t winner
);

  // A lone requester always wins; on conflict D wins (fixed) or the one not served last
  always_comb begin
    winner = NONE;
    if (req_i && req_d) begin
      if (FIXED_PRIO != 0) begin
        winner = DCACHE;
      end else begin
        winner = (last_served == ICACHE) ? DCACHE : ICACHE;
      end
    end else if (req_i) begin
      winner = ICACHE;
    end else if (req_d) begin
      winner = DCACHE;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - shares the unified L2 between the I-cache and D-cache miss paths
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W     = $bits(lc3b_word),
  parameter int BLOCK_W    = $bits(lc3b_block),
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               icache_mem_read,
  input  logic [ADDR_W-1:0]  icache_mem_address,
  output logic               icache_mem_resp,
  output logic [BLOCK_W-1:0] icache_mem_rdata,
  input  logic               dcache_mem_read,
  input  logic               dcache_mem_write,
  input  logic [ADDR_W-1:0]  dcache_mem_address,
  input  logic [BLOCK_W-1:0] dcache_mem_wdata,
  output logic               dcache_mem_resp,
  output logic [BLOCK_W-1:0] dcache_mem_rdata,
  output logic               l2arb_mem_read,
  output logic               l2arb_mem_write,
  output logic [ADDR_W-1:0]  l2arb_mem_address,
  output logic [BLOCK_W-1:0] l2arb_mem_wdata,
  input  logic               l2arb_mem_resp,
  input  logic [BLOCK_W-1:0] l2arb_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t       state;
  l2arb_grant_t grant;
  l2arb_grant_t last_served;
  l2arb_grant_t winner;
  logic         req_i;
  logic         req_d;
  logic         in_busy;

  assign req_i   = icache_mem_read;
  assign req_d   = dcache_mem_read | dcache_mem_write;
  assign in_busy = (state == S_BUSY);

  l2arb_rr_select #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_select (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_served (last_served),
    .winner      (winner)
  );

  // Response is steered only to the owner, and only while a transaction is in flight
  assign icache_mem_resp  = in_busy && l2arb_mem_resp && (grant == ICACHE);
  assign dcache_mem_resp  = in_busy && l2arb_mem_resp && (grant == DCACHE);
  assign icache_mem_rdata = l2arb_mem_rdata;
  assign dcache_mem_rdata = l2arb_mem_rdata;

  // Arbitration FSM: capture winner in IDLE, hold through BUSY, one dead cycle in RELEASE
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      grant             <= NONE;
      last_served       <= DCACHE;
      l2arb_mem_read    <= 1'b0;
      l2arb_mem_write   <= 1'b0;
      l2arb_mem_address <= '0;
      l2arb_mem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (winner == ICACHE) begin
            grant             <= ICACHE;
            last_served       <= ICACHE;
            l2arb_mem_address <= icache_mem_address;
            l2arb_mem_read    <= 1'b1;
            l2arb_mem_write   <= 1'b0;
            state             <= S_BUSY;
          end else if (winner == DCACHE) begin
            // read+write together is illegal; the write takes precedence
            grant             <= DCACHE;
            last_served       <= DCACHE;
            l2arb_mem_address <= dcache_mem_address;
            l2arb_mem_wdata   <= dcache_mem_wdata;
            l2arb_mem_read    <= ~dcache_mem_write;
            l2arb_mem_write   <= dcache_mem_write;
            state             <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (l2arb_mem_resp) begin
            grant           <= NONE;
            l2arb_mem_read  <= 1'b0;
            l2arb_mem_write <= 1'b0;
            state           <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - self-checking bench for l2_arbiter, round-robin and fixed-priority
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_rd;
  logic [15:0]  i_addr;
  logic         d_rd;
  logic         d_wr;
  logic [15:0]  d_addr;
  logic [127:0] d_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  logic [1:0]   o_iresp, o_dresp, o_rd, o_wr;
  logic [127:0] o_irdata [2];
  logic [127:0] o_drdata [2];
  logic [15:0]  o_addr   [2];
  logic [127:0] o_wdata  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int d_pulses = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(16), .BLOCK_W(128), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .icache_mem_read(i_rd), .icache_mem_address(i_addr),
    .icache_mem_resp(o_iresp[0]), .icache_mem_rdata(o_irdata[0]),
    .dcache_mem_read(d_rd), .dcache_mem_write(d_wr),
    .dcache_mem_address(d_addr), .dcache_mem_wdata(d_wdata),
    .dcache_mem_resp(o_dresp[0]), .dcache_mem_rdata(o_drdata[0]),
    .l2arb_mem_read(o_rd[0]), .l2arb_mem_write(o_wr[0]),
    .l2arb_mem_address(o_addr[0]), .l2arb_mem_wdata(o_wdata[0]),
    .l2arb_mem_resp(l2_resp), .l2arb_mem_rdata(l2_rdata)
  );

  l2_arbiter #(.ADDR_W(16), .BLOCK_W(128), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .icache_mem_read(i_rd), .icache_mem_address(i_addr),
    .icache_mem_resp(o_iresp[1]), .icache_mem_rdata(o_irdata[1]),
    .dcache_mem_read(d_rd), .dcache_mem_write(d_wr),
    .dcache_mem_address(d_addr), .dcache_mem_wdata(d_wdata),
    .dcache_mem_resp(o_dresp[1]), .dcache_mem_rdata(o_drdata[1]),
    .l2arb_mem_read(o_rd[1]), .l2arb_mem_write(o_wr[1]),
    .l2arb_mem_address(o_addr[1]), .l2arb_mem_wdata(o_wdata[1]),
    .l2arb_mem_resp(l2_resp), .l2arb_mem_rdata(l2_rdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the L2 port, and whether we are in the cool-down cycle
  int           m_owner [2];
  bit           m_cool  [2];
  int           m_last  [2];
  logic [15:0]  m_addr  [2];
  logic [127:0] m_wdata [2];
  bit           m_rd    [2];
  bit           m_wr    [2];
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = 0; m_cool[k] = 1'b0; m_last[k] = 2;
        m_addr[k] = '0; m_wdata[k] = '0; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
      end else if (m_owner[k] != 0) begin
        if (l2_resp) begin
          m_owner[k] = 0; m_cool[k] = 1'b1; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
        end
      end else if (m_cool[k]) begin
        m_cool[k] = 1'b0;
      end else begin
        int  pick;
        bit  wants_i;
        bit  wants_d;
        wants_i = i_rd;
        wants_d = d_rd | d_wr;
        if (wants_i && wants_d) pick = (k == 1) ? 2 : ((m_last[k] == 1) ? 2 : 1);
        else if (wants_i)       pick = 1;
        else if (wants_d)       pick = 2;
        else                    pick = 0;
        if (pick == 1) begin
          m_owner[k] = 1; m_last[k] = 1; m_addr[k] = i_addr; m_rd[k] = 1'b1; m_wr[k] = 1'b0;
        end else if (pick == 2) begin
          m_owner[k] = 2; m_last[k] = 2; m_addr[k] = d_addr; m_wdata[k] = d_wdata;
          m_wr[k] = d_wr; m_rd[k] = ~d_wr;
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Every-cycle comparison of both arbiters against the model
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_read", k),  {127'b0, o_rd[k]}, {127'b0, m_rd[k]});
        chk($sformatf("m%0d_write", k), {127'b0, o_wr[k]}, {127'b0, m_wr[k]});
        chk($sformatf("m%0d_addr", k),  {112'b0, o_addr[k]}, {112'b0, m_addr[k]});
        chk($sformatf("m%0d_wdata", k), o_wdata[k], m_wdata[k]);
        chk($sformatf("m%0d_iresp", k), {127'b0, o_iresp[k]},
            {127'b0, (m_owner[k] == 1) && l2_resp});
        chk($sformatf("m%0d_dresp", k), {127'b0, o_dresp[k]},
            {127'b0, (m_owner[k] == 2) && l2_resp});
        chk($sformatf("m%0d_irdata", k), o_irdata[k], l2_rdata);
        chk($sformatf("m%0d_drdata", k), o_drdata[k], l2_rdata);
      end
      if (o_dresp[0]) d_pulses++;
    end
  end

  logic [15:0] g0 [4];
  logic [15:0] g1 [4];

  task automatic wait_l2();
    int budget;
    budget = 0;
    while (!(o_rd[0] | o_wr[0]) && budget < 20) begin
      tick();
      budget++;
    end
    if (budget >= 20) chk("l2_request_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    rst = 1'b1; i_rd = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; l2_resp = 1'b0; l2_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_read",  {127'b0, o_rd[0]}, 128'd0);
    chk("reset_addr",  {112'b0, o_addr[0]}, 128'd0);

    // I-only read at 0x1230, resp 5 cycles after read rises
    i_rd = 1'b1; i_addr = 16'h1230;
    tick();
    chk("i_addr_n1", {112'b0, o_addr[0]}, 128'h1230);
    chk("i_read_n1", {127'b0, o_rd[0]}, 128'd1);
    repeat (5) tick();
    l2_resp = 1'b1; l2_rdata = {16{8'hA5}};
    #1;
    chk("i_resp",   {127'b0, o_iresp[0]}, 128'd1);
    chk("i_rdata",  o_irdata[0], {16{8'hA5}});
    chk("i_dresp0", {127'b0, o_dresp[0]}, 128'd0);
    tick();
    l2_resp = 1'b0; i_rd = 1'b0;
    chk("release_rd", {127'b0, o_rd[0]}, 128'd0);
    chk("release_wr", {127'b0, o_wr[0]}, 128'd0);
    tick();

    // D write at 0x4440, inputs disturbed mid-transaction
    d_pulses = 0;
    d_wr = 1'b1; d_addr = 16'h4440; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    tick();
    chk("d_write",   {127'b0, o_wr[0]}, 128'd1);
    chk("d_wdata_a", o_wdata[0], 128'h0123456789ABCDEF0123456789ABCDEF);
    d_addr = 16'hFFFF; d_wdata = '0;
    tick(); tick();
    chk("d_wdata_b", o_wdata[0], 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("d_addr_b",  {112'b0, o_addr[0]}, 128'h4440);
    l2_resp = 1'b1; l2_rdata = 128'h5A;
    tick();
    l2_resp = 1'b0; d_wr = 1'b0;
    tick(); tick();
    chk("d_pulses", d_pulses, 128'd1);

    // Conflict straight after reset, both held for four transactions
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_rd = 1'b1; i_addr = 16'h0010; d_rd = 1'b1; d_addr = 16'h8000;
    for (int n = 0; n < 4; n++) begin
      wait_l2();
      g0[n] = o_addr[0];
      g1[n] = o_addr[1];
      tick();
      l2_resp = 1'b1; l2_rdata = 128'h100 + 128'(n);
      tick();
      l2_resp = 1'b0;
      tick();
    end
    i_rd = 1'b0; d_rd = 1'b0;
    chk("rr_g0", {112'b0, g0[0]}, 128'h0010);
    chk("rr_g1", {112'b0, g0[1]}, 128'h8000);
    chk("rr_g2", {112'b0, g0[2]}, 128'h0010);
    chk("rr_g3", {112'b0, g0[3]}, 128'h8000);
    for (int n = 0; n < 4; n++) chk($sformatf("fixed_g%0d", n), {112'b0, g1[n]}, 128'h8000);

    // Spurious L2 response in IDLE
    tick();
    l2_resp = 1'b1; l2_rdata = 128'hDEAD;
    #1;
    chk("spur_iresp", {126'b0, o_iresp}, 128'd0);
    chk("spur_dresp", {126'b0, o_dresp}, 128'd0);
    tick();
    l2_resp = 1'b0;
    chk("spur_rd", {127'b0, o_rd[0]}, 128'd0);
    i_rd = 1'b1; i_addr = 16'h0ABC;
    tick();
    chk("spur_idle_grant", {127'b0, o_rd[0]}, 128'd1);
    chk("spur_idle_addr",  {112'b0, o_addr[0]}, 128'h0ABC);

    // Reset in the middle of BUSY, then a conflict
    rst = 1'b1;
    tick();
    chk("rst_busy_rd", {126'b0, o_rd}, 128'd0);
    rst = 1'b0;
    i_addr = 16'h0010; d_rd = 1'b1; d_addr = 16'h8000;
    tick();
    chk("post_rst_rr",    {112'b0, o_addr[0]}, 128'h0010);
    chk("post_rst_fixed", {112'b0, o_addr[1]}, 128'h8000);
    l2_resp = 1'b1; l2_rdata = 128'h77;
    tick();
    l2_resp = 1'b0; i_rd = 1'b0; d_rd = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single unified L2 cache between the I-cache and D-cache miss paths.
- Accepts one block-level read or write request from each L1 and selects a winner.
- Captures the winner's address and write data, then drives the L2 request interface (l2arb_mem_*) until the L2 responds.
- Steers the response and read block back to the winner only, then forces one idle cycle so the L2 controller returns to its idle state before the next request.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word).
- BLOCK_W, 128, cache line width (lc3b_block).
- FIXED_PRIO, 0. 0 = round-robin on conflict; 1 = D-cache always wins on conflict.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- icache_mem_read  in  1  I-cache line read request, held until icache_mem_resp
- icache_mem_address  in  ADDR_W  I-cache line address
- icache_mem_resp  out  1  I-cache response, single-cycle pulse
- icache_mem_rdata  out  BLOCK_W  read block returned to the I-cache
- dcache_mem_read  in  1  D-cache line read request
- dcache_mem_write  in  1  D-cache line write request (writeback)
- dcache_mem_address  in  ADDR_W  D-cache line address
- dcache_mem_wdata  in  BLOCK_W  D-cache write block
- dcache_mem_resp  out  1  D-cache response pulse
- dcache_mem_rdata  out  BLOCK_W  read block returned to the D-cache
- l2arb_mem_read  out  1  read request to L2, registered
- l2arb_mem_write  out  1  write request to L2, registered
- l2arb_mem_address  out  ADDR_W  captured address, registered
- l2arb_mem_wdata  out  BLOCK_W  captured write block, registered
- l2arb_mem_resp  in  1  L2 done, single-cycle pulse
- l2arb_mem_rdata  in  BLOCK_W  L2 read block, valid while l2arb_mem_resp is high

Behaviour:
- Reset, sampled on the clk edge:
  - State goes to IDLE.
  - l2arb_mem_read and l2arb_mem_write go to 0; address and wdata registers go to 0.
  - Grant register goes to NONE; last_served goes to DCACHE, so the first conflict grants the I-cache.
  - icache_mem_resp and dcache_mem_resp are 0.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Evaluate the request lines: req_i = icache_mem_read; req_d = dcache_mem_read | dcache_mem_write.
  - Only one requester active: grant it.
  - Both active: FIXED_PRIO=1 grants D; FIXED_PRIO=0 grants the requester that is not last_served.
  - On grant, on the same edge: load the address, wdata (D only) and read/write flags into the output registers, set the grant register, set last_served, and go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - Hold all l2arb_mem_* outputs constant.
  - When l2arb_mem_resp=1, combinationally assert resp to the granted requester only. Its rdata port follows l2arb_mem_rdata.
  - The non-granted requester's resp is always 0.
  - Next state is RELEASE, and l2arb_mem_read/l2arb_mem_write are cleared on that edge.
- RELEASE:
  - All L2 request outputs are 0 for exactly one cycle, so the L2 controller observes no request; this prevents a re-triggered lookup.
  - Next state is IDLE.
  - Requests are not sampled here.
- Latency:
  - Request sampled in IDLE at cycle n → l2arb_mem_* valid at cycle n+1.
  - Requester resp is issued in the same cycle as l2arb_mem_resp.
  - Minimum request-to-request spacing on the L2 port is two cycles after resp (RELEASE, then IDLE).
- The rdata outputs pass through combinationally in all states; consumers qualify them with resp.
- Requester protocol: hold the request and payload stable until resp. A request that drops while its grant is pending is still completed to L2; its resp is issued and ignored.
- D-cache asserting read and write together is illegal; the arbiter treats it as a write.
- A non-granted requester waits in IDLE arbitration with no timeout. Round-robin bounds the wait to one transaction.
- A spurious l2arb_mem_resp in IDLE or RELEASE is ignored: no requester resp, no state change.
- Reset mid-BUSY: the L2 request drops immediately and the in-flight response is lost. L2 control and the L1s are reset by the same rst.

Decomposition:
- lc3b_types supplies lc3b_word and lc3b_block.
- Add a typedef l2arb_grant_t {NONE, ICACHE, DCACHE} to lc3b_types for reuse by the performance-counter logic.
- The state enum stays local to the module.
- One sub-module: l2arb_rr_select. It is purely combinational: req_i, req_d, last_served and FIXED_PRIO in, winner out. It is unit-tested separately.

Test Plan:
- I-only read at 0x1230, L2 resp 5 cycles after l2arb_mem_read rises with rdata 0xA5…A5:
  - l2arb_mem_address=0x1230 one cycle after the request.
  - icache_mem_resp=1 and icache_mem_rdata=0xA5…A5 in the resp cycle.
  - dcache_mem_resp stays 0.
  - Both L2 request lines are 0 in the following cycle.
- D write at 0x4440 with wdata 0x0123…CDEF:
  - l2arb_mem_write=1 with the captured wdata, stable through BUSY even if the D-cache inputs change mid-transaction.
  - dcache_mem_resp is pulsed once.
- Simultaneous I read 0x0010 and D read 0x8000 straight after reset, FIXED_PRIO=0:
  - I is served first, then D.
  - With both held continuously, grants alternate I, D, I, D.
- Same conflict with FIXED_PRIO=1: D is granted every conflict.
- l2arb_mem_resp pulsed while in IDLE: no requester resp and no state change.
- rst asserted mid-BUSY:
  - Next cycle: l2arb_mem_read=0, state IDLE.
  - A subsequent I/D conflict grants I.
